// File: rtl/logic_op_pipe_if.sv
// Command/result handshake bundle for logic_op_pipe: command side, result side
// and the occupancy/completion status outputs.
interface logic_op_pipe_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_a;
  logic [3:0]    in_b;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_result;
  logic [1:0]    out_op;
  logic          out_zero;
  logic [CW-1:0] fifo_count;
  logic [7:0]    done_cnt;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, fifo_count, done_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, fifo_count, done_cnt
  );
endinterface

// File: rtl/logic_op_pipe.sv
// FIFO-buffered 4-bit logic op stage: commands queue in a DEPTH-entry FIFO, the
// head is evaluated by logic_unit and the result lands in an output register.
module logic_unit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [3:0] y
);
  always_comb begin
    y = 4'h0;
    case (op)
      2'b00: y = a & b;
      2'b01: y = a | b;
      2'b10: y = a ^ b;
      2'b11: y = ~a;
      default: y = 4'h0;
    endcase
  end
endmodule

module logic_op_pipe #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  logic_op_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          vld_q;
  logic [3:0]    res_q;
  logic [1:0]    op_q;
  logic          zero_q;
  logic [7:0]    done_q;

  cmd_t       head;
  logic [3:0] lu_y;
  logic       push, issue, fire;

  // in_ready looks only at occupancy, so a full FIFO never takes a push even
  // when the head drains in the same cycle.
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign issue        = (count != '0) && (!vld_q || bus.out_ready);
  assign fire         = vld_q && bus.out_ready;
  assign head         = mem[rd_ptr];

  logic_unit u_lu (.a(head.a), .b(head.b), .op(head.op), .y(lu_y));

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= 1'b0;
      res_q  <= 4'h0;
      op_q   <= 2'b00;
      zero_q <= 1'b0;
      done_q <= 8'h00;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      if (push && !issue)      count <= count + 1'b1;
      else if (!push && issue) count <= count - 1'b1;
      if (issue) begin
        vld_q  <= 1'b1;
        res_q  <= lu_y;
        op_q   <= head.op;
        zero_q <= (lu_y == 4'h0);
      end else if (fire) begin
        vld_q  <= 1'b0;
      end
      if (fire) done_q <= done_q + 8'd1;
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.out_result = res_q;
  assign bus.out_op     = op_q;
  assign bus.out_zero   = zero_q;
  assign bus.fifo_count = count;
  assign bus.done_cnt   = done_q;
endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: expected results are queued at push time
// and popped by a negedge monitor on every output handshake.
module tb_logic_op_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_op_pipe_if #(.DEPTH(4)) bus ();
  logic_op_pipe #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int done_m = 0;
  logic [6:0] exp_q [$];   // {zero, op, result}

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [3:0] a, b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_res(input logic [3:0] r, input logic [1:0] op);
    exp_q.push_back({(r == 4'h0), op, r});
  endtask

  // One-cycle push; waits (bounded) for in_ready, records the hand value.
  task automatic push_cmd(input logic [3:0] a, b, input logic [1:0] op, input logic [3:0] r);
    int guard = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op;
    while (!bus.in_ready && guard < 50) begin step(); guard++; end
    if (guard >= 50) chk("push_timeout", 0, 1);
    expect_res(r, op);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Output handshakes happen on the next rising edge; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("sb_result", bus.out_result, e[3:0]);
        chk("sb_op",     bus.out_op,     e[5:4]);
        chk("sb_zero",   bus.out_zero,   e[6]);
      end
      done_m++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int pushed;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready",  bus.in_ready,   1);
    chk("rst_out_valid", bus.out_valid,  0);
    chk("rst_count",     bus.fifo_count, 0);
    chk("rst_done",      bus.done_cnt,   0);
    chk("rst_result",    bus.out_result, 0);
    step(2);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Opcodes, back to back, with latency and throughput checks
    bus.out_ready = 1'b1;
    push_cmd(4'hC, 4'hA, 2'b00, 4'h8);
    chk("lat_edge_n", bus.out_valid, 0);
    push_cmd(4'hC, 4'hA, 2'b01, 4'hE);
    chk("lat_edge_n1", bus.out_valid, 1);
    chk("tput_count1", bus.fifo_count, 1);
    push_cmd(4'hC, 4'hA, 2'b10, 4'h6);
    chk("tput_count2", bus.fifo_count, 1);
    push_cmd(4'hC, 4'hA, 2'b11, 4'h3);
    chk("tput_count3", bus.fifo_count, 1);
    step(3);
    chk("ops_done4", bus.done_cnt, 4);
    chk("ops_idle_valid", bus.out_valid, 0);
    chk("ops_hold_result", bus.out_result, 4'h3);

    // Zero flag
    push_cmd(4'h5, 4'h5, 2'b10, 4'h0);
    step();
    chk("zero_xor", bus.out_zero, 1);
    push_cmd(4'hF, 4'h0, 2'b11, 4'h0);
    step();
    chk("zero_not", bus.out_zero, 1);
    step(2);

    // Backpressure: 6 offered, 5 fit (4 in FIFO + 1 in output register)
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] av, rv;
      av = 4'(i + 1);
      rv = ref_op(av, 4'h9, 2'(i));
      bus.in_valid = 1'b1; bus.in_a = av; bus.in_b = 4'h9; bus.in_op = 2'(i);
      if (bus.in_ready) begin expect_res(rv, 2'(i)); acc++; end
      step();
    end
    chk("bp_accepted", acc, 5);
    chk("bp_count", bus.fifo_count, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_head_result", bus.out_result, 4'h1);
    step(2);
    chk("bp_hold_result", bus.out_result, 4'h1);
    chk("bp_hold_op", bus.out_op, 0);
    chk("bp_hold_valid", bus.out_valid, 1);

    // Full FIFO, pop and offered push in the same cycle: push refused
    bus.out_ready = 1'b1;
    bus.in_a = 4'h6; bus.in_b = 4'h9; bus.in_op = 2'b01;
    step();
    chk("full_pop_count", bus.fifo_count, 3);
    chk("full_pop_ready", bus.in_ready, 1);
    expect_res(4'hF, 2'b01);
    step();
    chk("full_next_push_count", bus.fifo_count, 3);
    bus.in_valid = 1'b0;
    step(8);
    chk("bp_drain_ready", bus.in_ready, 1);
    chk("bp_drain_count", bus.fifo_count, 0);
    chk("bp_done", bus.done_cnt, 12);

    // Pointer and done_cnt wrap with random traffic: 244 more completions -> 256
    pushed = 0;
    for (int cyc = 0; cyc < 3000 && pushed < 244; cyc++) begin
      logic [3:0] a, b;
      logic [1:0] op;
      a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_a = a; bus.in_b = b; bus.in_op = op;
      if (bus.in_valid && bus.in_ready) begin expect_res(ref_op(a, b, op), op); pushed++; end
      step();
    end
    chk("wrap_pushed", pushed, 244);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(10);
    chk("wrap_done_model", done_m, 256);
    chk("wrap_done_cnt", bus.done_cnt, 0);
    chk("wrap_sb_empty", exp_q.size(), 0);

    // Reset mid-stream: 3 queued + 1 pending
    bus.out_ready = 1'b0;
    push_cmd(4'h7, 4'h3, 2'b01, 4'h7);
    push_cmd(4'h1, 4'h2, 2'b01, 4'h3);
    push_cmd(4'h4, 4'h2, 2'b01, 4'h6);
    push_cmd(4'h8, 4'h1, 2'b01, 4'h9);
    chk("mid_count3", bus.fifo_count, 3);
    chk("mid_valid", bus.out_valid, 1);
    chk("mid_result", bus.out_result, 4'h7);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    done_m = 0;
    #1;
    chk("arst_valid",  bus.out_valid,  0);
    chk("arst_count",  bus.fifo_count, 0);
    chk("arst_result", bus.out_result, 0);
    chk("arst_op",     bus.out_op,     0);
    chk("arst_zero",   bus.out_zero,   0);
    chk("arst_done",   bus.done_cnt,   0);
    chk("arst_ready",  bus.in_ready,   1);
    step(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step(4);
    chk("post_arst_valid", bus.out_valid, 0);
    chk("post_arst_done",  bus.done_cnt,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
